instruction_decode: RTL and testbench

Decode stage of the single-cycle LEGv8 (ARMv8 subset) processor. It sits between instruction fetch and execute. It takes the fetched 32-bit instruction and its 64-bit PC, and classifies the format. It also holds the 32×64 register file and produces the datapath control signals. It resolves branches, driving `PCSrc` and `BranchAddress` back to fetch in the same cycle.

---
 rtl/legv8_pkg.sv | 71 +++++++
 rtl/register_file.sv | 31 +++
 rtl/instruction_decode.sv | 171 +++++++++++++++++
 tb/tb_instruction_decode.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALUOp encoding and condition codes.
// Also holds the instruction format enumeration and the B.cond evaluation helper.
package legv8_pkg;

  // R-type and D-type opcodes, matched on instruction[31:21]
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLsl  = 11'b11010011011;
  localparam logic [10:0] OpLsr  = 11'b11010011010;
  localparam logic [10:0] OpBr   = 11'b11010110000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpHalt = 11'b11111111111;

  // I-type on [31:22], CB on [31:24], B on [31:26]
  localparam logic [9:0] OpAddi  = 10'b1001000100;
  localparam logic [9:0] OpSubi  = 10'b1101000100;
  localparam logic [7:0] OpCbz   = 8'b10110100;
  localparam logic [7:0] OpCbnz  = 8'b10110101;
  localparam logic [7:0] OpBcond = 8'b01010100;
  localparam logic [5:0] OpB     = 6'b000101;
  localparam logic [5:0] OpBl    = 6'b100101;

  localparam logic [31:0] NopInsn  = 32'hD503201F;
  localparam logic [31:0] HaltInsn = 32'hFFE00000;

  typedef enum logic [1:0] {
    AluAdd  = 2'b00,
    AluPass = 2'b01,
    AluFunc = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    CondEq, CondNe, CondCs, CondCc, CondMi, CondPl, CondVs, CondVc,
    CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
  } cond_e;

  typedef enum logic [3:0] {
    FmtIllegal, FmtR, FmtShift, FmtBr, FmtLdur, FmtStur, FmtI,
    FmtCbz, FmtCbnz, FmtBcond, FmtB, FmtBl, FmtNop, FmtHalt
  } fmt_e;

  // nzcv = {N, Z, C, V}
  function automatic logic cond_holds(input cond_e c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    n  = nzcv[3];
    z  = nzcv[2];
    cf = nzcv[1];
    v  = nzcv[0];
    unique case (c)
      CondEq:  cond_holds = z;
      CondNe:  cond_holds = !z;
      CondCs:  cond_holds = cf;
      CondCc:  cond_holds = !cf;
      CondMi:  cond_holds = n;
      CondPl:  cond_holds = !n;
      CondVs:  cond_holds = v;
      CondVc:  cond_holds = !v;
      CondHi:  cond_holds = cf && !z;
      CondLs:  cond_holds = !cf || z;
      CondGe:  cond_holds = (n == v);
      CondLt:  cond_holds = (n != v);
      CondGt:  cond_holds = !z && (n == v);
      CondLe:  cond_holds = z || (n != v);
      default: cond_holds = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x64 LEGv8 register file: two asynchronous read ports, one synchronous write port.
// X31 reads as zero and ignores writes; active-low reset clears every register at once.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [63:0] rdata1,
  output logic [63:0] rdata2,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata
);

  logic [63:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 64'd0;
      end
    end else if (wen && (waddr != 5'd31)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: a read in the write cycle sees the old value.
  assign rdata1 = (raddr1 == 5'd31) ? 64'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd31) ? 64'd0 : regs_q[raddr2];

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 decode stage: format classification, register read, immediate extension,
// control generation and same-cycle branch resolution back to fetch.
module instruction_decode
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [63:0] PC,
  input  logic [3:0]  flags,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [63:0] wb_data,
  output logic        PCSrc,
  output logic [63:0] BranchAddress,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2,
  output logic [63:0] sign_ext_imm,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Link,
  output logic [1:0]  ALUOp,
  output logic [4:0]  write_reg,
  output logic        halt,
  output logic        illegal
);

  fmt_e        fmt;
  aluop_e      alu_op;
  logic [10:0] op11;
  logic [63:0] pc_plus4;
  logic [63:0] b_target;
  logic [63:0] cb_target;

  assign op11 = instruction[31:21];

  always_comb begin
    fmt = FmtIllegal;
    if (op11 == OpHalt) begin
      fmt = FmtHalt;
    end else if (op11 == OpAdd || op11 == OpSub || op11 == OpAnd || op11 == OpOrr) begin
      fmt = FmtR;
    end else if (op11 == OpLsl || op11 == OpLsr) begin
      fmt = FmtShift;
    end else if (op11 == OpBr) begin
      fmt = FmtBr;
    end else if (op11 == OpLdur) begin
      fmt = FmtLdur;
    end else if (op11 == OpStur) begin
      fmt = FmtStur;
    end else if (instruction[31:22] == OpAddi || instruction[31:22] == OpSubi) begin
      fmt = FmtI;
    end else if (instruction[31:24] == OpCbz) begin
      fmt = FmtCbz;
    end else if (instruction[31:24] == OpCbnz) begin
      fmt = FmtCbnz;
    end else if (instruction[31:24] == OpBcond) begin
      fmt = FmtBcond;
    end else if (instruction[31:26] == OpB) begin
      fmt = FmtB;
    end else if (instruction[31:26] == OpBl) begin
      fmt = FmtBl;
    end else if (instruction == NopInsn) begin
      fmt = FmtNop;
    end
  end

  always_comb begin
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Link     = 1'b0;
    alu_op   = AluAdd;
    unique case (fmt)
      FmtR, FmtShift: begin
        RegWrite = 1'b1;
        alu_op   = AluFunc;
      end
      FmtI: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        alu_op   = AluFunc;
      end
      FmtLdur: begin
        ALUSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      FmtStur: begin
        Reg2Loc  = 1'b1;
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      FmtCbz, FmtCbnz, FmtBcond: begin
        Reg2Loc = 1'b1;
        Branch  = 1'b1;
        alu_op  = AluPass;
      end
      FmtB, FmtBr: Branch = 1'b1;
      FmtBl: begin
        Branch = 1'b1;
        Link   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUOp     = alu_op;
  assign halt      = (fmt == FmtHalt);
  assign illegal   = (fmt == FmtIllegal);
  assign write_reg = (fmt == FmtBl) ? 5'd30 : instruction[4:0];

  register_file u_register_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instruction[9:5]),
    .raddr2 (Reg2Loc ? instruction[4:0] : instruction[20:16]),
    .rdata1 (read_data1),
    .rdata2 (read_data2),
    .wen    (wb_en),
    .waddr  (wb_reg),
    .wdata  (wb_data)
  );

  always_comb begin
    unique case (fmt)
      FmtI:                   sign_ext_imm = {52'd0, instruction[21:10]};
      FmtLdur, FmtStur:       sign_ext_imm = {{55{instruction[20]}}, instruction[20:12]};
      FmtCbz, FmtCbnz,
      FmtBcond:               sign_ext_imm = {{45{instruction[23]}}, instruction[23:5]};
      FmtB, FmtBl:            sign_ext_imm = {{38{instruction[25]}}, instruction[25:0]};
      FmtShift:               sign_ext_imm = {58'd0, instruction[15:10]};
      default:                sign_ext_imm = 64'd0;
    endcase
  end

  always_comb begin
    unique case (fmt)
      FmtB, FmtBl, FmtBr: PCSrc = 1'b1;
      FmtCbz:             PCSrc = (read_data2 == 64'd0);
      FmtCbnz:            PCSrc = (read_data2 != 64'd0);
      FmtBcond:           PCSrc = cond_holds(cond_e'(instruction[3:0]), flags);
      default:            PCSrc = 1'b0;
    endcase
  end

  assign pc_plus4  = PC + 64'd4;
  assign b_target  = PC + {{36{instruction[25]}}, instruction[25:0], 2'b00};
  assign cb_target = PC + {{43{instruction[23]}}, instruction[23:5], 2'b00};

  // Untaken conditional branches hand fetch the fall-through address.
  always_comb begin
    unique case (fmt)
      FmtB, FmtBl:                BranchAddress = b_target;
      FmtCbz, FmtCbnz, FmtBcond:  BranchAddress = PCSrc ? cb_target : pc_plus4;
      FmtBr:                      BranchAddress = read_data1;
      default:                    BranchAddress = pc_plus4;
    endcase
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-encoded instructions with hand-computed results.
module tb_instruction_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [63:0] PC;
  logic [3:0]  flags;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] sign_ext_imm;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Link;
  logic [1:0]  ALUOp;
  logic [4:0]  write_reg;
  logic        halt;
  logic        illegal;
  logic [9:0]  ctrl;

  int n_tests;
  int n_fail;

  instruction_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .PC            (PC),
    .flags         (flags),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .PCSrc         (PCSrc),
    .BranchAddress (BranchAddress),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .sign_ext_imm  (sign_ext_imm),
    .Reg2Loc       (Reg2Loc),
    .ALUSrc        (ALUSrc),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Branch        (Branch),
    .Link          (Link),
    .ALUOp         (ALUOp),
    .write_reg     (write_reg),
    .halt          (halt),
    .illegal       (illegal)
  );

  // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Link, ALUOp}
  assign ctrl = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Link, ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    wb_en   = 1'b1;
    wb_reg  = r;
    wb_data = d;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic apply(input logic [31:0] insn, input logic [63:0] pc);
    instruction = insn;
    PC          = pc;
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instruction = 32'hD503201F;
    PC          = 64'h20;
    flags       = 4'b0000;
    wb_en       = 1'b0;
    wb_reg      = 5'd0;
    wb_data     = 64'd0;
    #2;
    check("reset_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("reset_baddr", BranchAddress, 64'h24);
    check("reset_ctrl", {54'd0, ctrl}, 64'd0);
    check("reset_halt_illegal", {62'd0, halt, illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // CBZ X1,#4 at 0x40
    wr(5'd1, 64'd0);
    apply({8'b10110100, 19'd4, 5'd1}, 64'h40);
    check("cbz_taken_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("cbz_taken_baddr", BranchAddress, 64'h50);
    check("cbz_ctrl", {54'd0, ctrl}, 64'b10_0000_1001);

    // CBNZ / CBZ X2,#-2 at 0x100 with X2=5
    wr(5'd2, 64'd5);
    apply({8'b10110101, 19'h7FFFE, 5'd2}, 64'h100);
    check("cbnz_taken_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("cbnz_taken_baddr", BranchAddress, 64'hF8);
    check("cb_imm", sign_ext_imm, 64'hFFFF_FFFF_FFFF_FFFE);
    apply({8'b10110100, 19'h7FFFE, 5'd2}, 64'h100);
    check("cbz_nt_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("cbz_nt_baddr", BranchAddress, 64'h104);

    // B imm26 = -1 at 0x100
    apply({6'b000101, 26'h3FFFFFF}, 64'h100);
    check("b_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("b_baddr", BranchAddress, 64'hFC);

    // NOP and HALT
    apply(32'hD503201F, 64'h20);
    check("nop_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("nop_baddr", BranchAddress, 64'h24);
    check("nop_ctrl", {54'd0, ctrl}, 64'd0);
    apply(32'hFFE00000, 64'h20);
    check("halt_flag", {63'd0, halt}, 64'd1);
    check("halt_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("halt_ctrl", {54'd0, ctrl}, 64'd0);

    // ADD X5,X3,X4
    wr(5'd3, 64'd7);
    wr(5'd4, 64'd9);
    apply({11'b10001011000, 5'd4, 6'd0, 5'd3, 5'd5}, 64'h0);
    check("add_rd1", read_data1, 64'd7);
    check("add_rd2", read_data2, 64'd9);
    check("add_ctrl", {54'd0, ctrl}, 64'b00_0100_0010);
    check("add_wreg", {59'd0, write_reg}, 64'd5);

    // XZR: write discarded, reads zero
    wr(5'd31, 64'hDEAD_BEEF);
    apply({11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd5}, 64'h0);
    check("xzr_rd1", read_data1, 64'd0);
    check("xzr_rd2", read_data2, 64'd0);

    // LDUR X6,[X3,#-8]
    apply({11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd6}, 64'h0);
    check("ldur_imm", sign_ext_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_ctrl", {54'd0, ctrl}, 64'b01_1110_0000);
    check("ldur_rd1", read_data1, 64'd7);

    // STUR X4,[X3,#16]: port 2 reads Rt
    apply({11'b11111000000, 9'd16, 2'b00, 5'd3, 5'd4}, 64'h0);
    check("stur_ctrl", {54'd0, ctrl}, 64'b11_0001_0000);
    check("stur_rd2", read_data2, 64'd9);

    // ADDI X1,X2,#0xFFF zero-extended
    apply({10'b1001000100, 12'hFFF, 5'd2, 5'd1}, 64'h0);
    check("addi_imm", sign_ext_imm, 64'hFFF);
    check("addi_ctrl", {54'd0, ctrl}, 64'b01_0100_0010);

    // LSL X1,X2,#13
    apply({11'b11010011011, 5'd0, 6'd13, 5'd2, 5'd1}, 64'h0);
    check("lsl_shamt", sign_ext_imm, 64'd13);

    // Illegal opcode
    apply(32'h00000000, 64'h10);
    check("illegal_flag", {63'd0, illegal}, 64'd1);
    check("illegal_pcsrc", {63'd0, PCSrc}, 64'd0);

    // BR X3 -> 7
    apply({11'b11010110000, 5'd31, 6'd0, 5'd3, 5'd0}, 64'h80);
    check("br_baddr", BranchAddress, 64'd7);
    check("br_pcsrc", {63'd0, PCSrc}, 64'd1);

    // BL #1 at 0x200
    apply({6'b100101, 26'd1}, 64'h200);
    check("bl_baddr", BranchAddress, 64'h204);
    check("bl_wreg", {59'd0, write_reg}, 64'd30);
    check("bl_ctrl", {54'd0, ctrl}, 64'b00_0000_1100);

    // B.cond #3 at 0x300
    flags = 4'b0100;
    apply({8'b01010100, 19'd3, 1'b0, 4'b0000}, 64'h300);
    check("beq_taken", BranchAddress, 64'h30C);
    flags = 4'b1000;
    apply({8'b01010100, 19'd3, 1'b0, 4'b1100}, 64'h300);
    check("bgt_nt_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("bgt_nt_baddr", BranchAddress, 64'h304);
    apply({8'b01010100, 19'd3, 1'b0, 4'b1011}, 64'h300);
    check("blt_taken", {63'd0, PCSrc}, 64'd1);
    flags = 4'b0000;
    apply({8'b01010100, 19'd3, 1'b0, 4'b0000}, 64'h300);
    check("beq_nt", {63'd0, PCSrc}, 64'd0);

    // No bypass: old value visible until the edge
    apply({11'b10001011000, 5'd7, 6'd0, 5'd7, 5'd5}, 64'h0);
    wb_en   = 1'b1;
    wb_reg  = 5'd7;
    wb_data = 64'h55;
    #1;
    check("nobypass_rd1", read_data1, 64'd0);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    check("written_rd1", read_data1, 64'h55);

    // Asynchronous reset clears the file
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_clear", read_data1, 64'd0);
    apply({11'b10001011000, 5'd4, 6'd0, 5'd3, 5'd5}, 64'h0);
    check("clear_rd1", read_data1, 64'd0);
    check("clear_rd2", read_data2, 64'd0);
    check("reset_add_ctrl", {54'd0, ctrl}, 64'b00_0100_0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
